bka_multiword_add_seq: RTL and testbench
========================================

// Module: bka_multiword_add_seq
// PURPOSE
// - Sequences one brent_kung_paralell_prefixAdder instance to add operands wider than N bits.
// - Operands arrive as a stream of N-bit words, least significant word first.
// - Carry is chained between words in a register; one registered sum word is produced per accepted word.
// - Sits between operand-producing logic (bignum/crypto datapath) and the result consumer.
// PARAMETERS
// - N      64  word width; passed straight through to the adder instance
// - CNT_W  8   width of the word-index counter; a single operation spans up to 2**CNT_W words
// PORTS
// - clk         in   1      rising-edge clock
// - rst_n       in   1      asynchronous, active-low reset
// - in_valid    in   1      input word valid
// - in_ready    out  1      input word accepted when in_valid & in_ready
// - in_a        in   N      operand A word
// - in_b        in   N      operand B word
// - in_first    in   1      first (least significant) word of an operation
// - in_last     in   1      last (most significant) word of an operation
// - in_cin      in   1      carry-in; sampled only on a first word
// - out_valid   out  1      result word valid
// - out_ready   in   1      consumer accepts the result word when out_valid & out_ready
// - out_sum     out  N      sum word
// - out_idx     out  CNT_W  word index within the operation; 0 for the first word
// - out_last    out  1      this is the final word of the operation
// - out_cout    out  1      final carry-out; meaningful only when out_last = 1, otherwise 0
// - busy        out  1      an operation is open (a first word accepted, its last word not yet accepted)
// - err_seq     out  1      sticky protocol error flag
// - err_clr     in   1      synchronous clear for err_seq
// BEHAVIOUR
// - Reset (rst_n = 0, asynchronous):
//   - out_valid, out_sum, out_idx, out_last, out_cout, err_seq, carry register, word counter all 0.
//   - FSM goes to IDLE.
//   - An operation in progress is discarded; no partial result is emitted after reset.
// - Handshake:
//   - in_ready = !out_valid | out_ready (single output register, no bubble).
//   - The adder is combinational; out_* are registered.
//   - Latency is 1 cycle from an accepted word to out_valid.
//   - While out_valid = 1 and out_ready = 0, all out_* hold stable.
// - Adder operands on an accepted word:
//   - a = in_a, b = in_b.
//   - cin = in_cin if in_first, otherwise the carry register.
//   - The adder's cout is loaded into the carry register.
// - FSM:
//   - IDLE:
//     - Accepted word with in_first goes to BUSY, or stays in IDLE if in_last is also set (single-word operation).
//     - Accepted word without in_first sets err_seq, is treated as a first word with cin = in_cin, and is still emitted.
//   - BUSY:
//     - Accepted word with in_last goes to IDLE.
//     - Accepted word with in_first sets err_seq and restarts: counter reset to 0, cin = in_cin.
// - Word counter:
//   - Resets to 0 on a first word and increments on each accepted word.
//   - Wrap past 2**CNT_W-1 sets err_seq; the count wraps to 0 and the carry chain continues.
// - out_cout = adder cout registered with out_last; 0 on non-last words.
// - err_clr and an error in the same cycle: the error wins (err_seq = 1).
// - busy is 1 in BUSY only.
// CONFIGURATION
// - BKA_SUB_EN defined:
//   - Adds input port in_sub (1 bit), sampled on a first word and held in a register for the whole operation.
//   - When set: b = ~in_b on every word, and cin on the first word is forced to 1 (A - B, two's complement).
//   - out_cout = 1 means no borrow.
// - BKA_SUB_EN undefined: port in_sub is absent; the block adds only.
// STRUCTURE
// - Shared package bka_pkg holds:
//   - FSM state typedef seq_state_t {IDLE, BUSY}.
//   - Default N and CNT_W constants.
// - Sub-module: the existing brent_kung_paralell_prefixAdder #(N), instantiated once; no other sub-modules.
// TESTING (N=8)
// - Single-word add: first & last, a=0x0F, b=0x01, cin=0 -> sum=0x10, idx=0, last=1, cout=0.
// - Two-word carry chain: (0xFF, 0x01, first), then (0x01, 0x00, last) -> 0x00, then 0x02 with cout=0.
// - Final overflow: first & last, a=0xF0, b=0x0F, cin=1 -> sum=0x00, cout=1.
// - Backpressure: hold out_ready=0 for 3 cycles mid-operation -> in_ready=0, out_* stable, no word lost or duplicated.
// - Protocol error: in_first in BUSY -> err_seq=1, idx restarts at 0; err_clr -> err_seq=0 next cycle.
// - Reset mid-operation: rst_n low after word 0 -> out_valid=0, busy=0 immediately; next first word uses in_cin, not the old carry.

Source files
------------

// File: rtl/bka_pkg.sv
// bka_pkg: shared types and defaults for the multiword Brent-Kung adder sequencer.
// Optional macro BKA_SUB_EN (subtract mode) is handled in the interface and top.
package bka_pkg;

  localparam int N_DEF     = 64;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } seq_state_t;

endpackage

// File: rtl/bka_multiword_add_seq_if.sv
// bka_multiword_add_seq_if: operand-in / sum-out valid-ready bundle.
// Macro BKA_SUB_EN adds the in_sub operand-mode signal.
interface bka_multiword_add_seq_if
  import bka_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_first;
  logic             in_last;
  logic             in_cin;
`ifdef BKA_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic [CNT_W-1:0] out_idx;
  logic             out_last;
  logic             out_cout;

  modport master (
`ifdef BKA_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b,
    output in_first, in_last, in_cin,
    input  in_ready,
    input  out_valid, out_sum, out_idx,
    input  out_last, out_cout,
    output out_ready
  );

  modport slave (
`ifdef BKA_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b,
    input  in_first, in_last, in_cin,
    output in_ready,
    output out_valid, out_sum, out_idx,
    output out_last, out_cout,
    input  out_ready
  );

endinterface

// File: rtl/brent_kung_paralell_prefixAdder.sv
// brent_kung_paralell_prefixAdder: combinational N-bit Brent-Kung adder.
// Carry-in is folded into bit 0 generate; requires N >= 2.
module brent_kung_paralell_prefixAdder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int L = (N > 1) ? $clog2(N) : 1;
  localparam int P = 1 << L;

  logic [P-1:0] p0;
  logic [P-1:0] gg;
  logic [P-1:0] pp;

  // up-sweep then down-sweep prefix tree over (g, p) pairs
  always_comb begin
    p0 = '0;
    gg = '0;
    p0[N-1:0] = a ^ b;
    gg[N-1:0] = a & b;
    gg[0] = gg[0] | (p0[0] & cin);
    pp = p0;
    for (int s = 1; s < P; s = s * 2) begin
      for (int i = 2 * s - 1; i < P; i = i + 2 * s) begin
        gg[i] = gg[i] | (pp[i] & gg[i-s]);
        pp[i] = pp[i] & pp[i-s];
      end
    end
    for (int s = P / 4; s >= 1; s = s / 2) begin
      for (int i = 3 * s - 1; i < P; i = i + 2 * s) begin
        gg[i] = gg[i] | (pp[i] & gg[i-s]);
      end
    end
    sum  = p0[N-1:0] ^ {gg[N-2:0], cin};
    cout = gg[N-1];
  end

endmodule

// File: rtl/bka_multiword_add_seq.sv
// bka_multiword_add_seq: streams wide operands word by word through one adder.
// Macro BKA_SUB_EN enables A - B mode via in_sub latched on the first word.
module bka_multiword_add_seq
  import bka_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  bka_multiword_add_seq_if.slave bus,
  output logic busy,
  output logic err_seq,
  input  logic err_clr
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             acc;
  logic             first_eff;
  logic             seq_err;
  logic             wrap_err;
  logic             cin_eff;
  logic             carry_q;
  logic             add_cout;
  logic [N-1:0]     b_eff;
  logic [N-1:0]     add_sum;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_cur;

  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign acc = bus.in_valid & bus.in_ready;

  // a stray word in IDLE is handled as the start of a new operation
  assign first_eff = bus.in_first | (state == IDLE);
  assign idx_cur   = first_eff ? '0 : cnt_q;

  assign seq_err = acc & ((state == IDLE & !bus.in_first)
                        | (state == BUSY & bus.in_first));
  assign wrap_err = acc & !bus.in_last & (&idx_cur);

`ifdef BKA_SUB_EN
  logic sub_q;
  logic sub_eff;

  assign sub_eff = first_eff ? bus.in_sub : sub_q;
  assign b_eff   = sub_eff ? ~bus.in_b : bus.in_b;
  assign cin_eff = first_eff ? (bus.in_sub | bus.in_cin) : carry_q;

  // operation mode held for every word of the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (acc) begin
      sub_q <= sub_eff;
    end
  end
`else
  assign b_eff   = bus.in_b;
  assign cin_eff = first_eff ? bus.in_cin : carry_q;
`endif

  brent_kung_paralell_prefixAdder #(.N(N)) u_add (
    .a    (bus.in_a),
    .b    (b_eff),
    .cin  (cin_eff),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: any accepted word opens or closes by in_last
  always_comb begin
    state_nxt = state;
    if (acc) begin
      state_nxt = bus.in_last ? IDLE : BUSY;
    end
  end

  // FSM outputs
  always_comb begin
    busy = (state == BUSY);
  end

  // carry chain and word index between words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (acc) begin
      carry_q <= add_cout;
      cnt_q   <= idx_cur + CNT_W'(1);
    end
  end

  // single output register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_cout  <= 1'b0;
    end else if (acc) begin
      bus.out_valid <= 1'b1;
      bus.out_sum   <= add_sum;
      bus.out_idx   <= idx_cur;
      bus.out_last  <= bus.in_last;
      bus.out_cout  <= bus.in_last & add_cout;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // sticky error flag; a new error beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq <= 1'b0;
    end else if (seq_err | wrap_err) begin
      err_seq <= 1'b1;
    end else if (err_clr) begin
      err_seq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bka_multiword_add_seq.sv
// tb_bka_multiword_add_seq: table vectors plus hand sequences, scoreboarded.
// Runs with N=8, CNT_W=3 so the index wrap is reachable.
module tb_bka_multiword_add_seq;

  localparam int N  = 8;
  localparam int CW = 3;

  typedef struct packed {
    logic [N-1:0]  sum;
    logic [CW-1:0] idx;
    logic          last;
    logic          cout;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         f;
    logic         l;
    logic         c;
    exp_t         e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic busy;
  logic err_seq;

  exp_t q[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;

  bka_multiword_add_seq_if #(.N(N), .CNT_W(CW)) ifc ();

  bka_multiword_add_seq #(.N(N), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc.slave),
    .busy    (busy),
    .err_seq (err_seq),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_e(input logic [N-1:0] s, input int idx,
                                input logic l, input logic c);
    exp_t e;
    e.sum  = s;
    e.idx  = CW'(idx);
    e.last = l;
    e.cout = c;
    return e;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic f, input logic l, input logic c,
                              input exp_t e);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.l = l; v.c = c; v.e = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic f, input logic l, input logic c,
                      input exp_t e);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    ifc.in_a = a;
    ifc.in_b = b;
    ifc.in_first = f;
    ifc.in_last = l;
    ifc.in_cin = c;
    ifc.in_valid = 1'b1;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (ifc.in_ready) ok = 1'b1;
      else begin
        n++;
        step();
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      q.push_back(e);
    end
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  // scoreboard: compare each word the consumer takes
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none",
                 ifc.out_sum);
      end else begin
        chk("out_word",
            {ifc.out_sum, ifc.out_idx, ifc.out_last, ifc.out_cout},
            q.pop_front());
      end
    end
  end

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    ifc.in_first = 1'b0;
    ifc.in_last = 1'b0;
    ifc.in_cin = 1'b0;
    ifc.out_ready = 1'b1;
`ifdef BKA_SUB_EN
    ifc.in_sub = 1'b0;
`endif

    tbl[0] = mk(8'h0F, 8'h01, 1, 1, 0, mk_e(8'h10, 0, 1, 0));
    tbl[1] = mk(8'hFF, 8'h01, 1, 0, 0, mk_e(8'h00, 0, 0, 0));
    tbl[2] = mk(8'h01, 8'h00, 0, 1, 0, mk_e(8'h02, 1, 1, 0));
    tbl[3] = mk(8'hF0, 8'h0F, 1, 1, 1, mk_e(8'h00, 0, 1, 1));
    tbl[4] = mk(8'h80, 8'h80, 1, 0, 0, mk_e(8'h00, 0, 0, 0));
    tbl[5] = mk(8'h7F, 8'h00, 0, 0, 1, mk_e(8'h80, 1, 0, 0));
    tbl[6] = mk(8'hFF, 8'hFF, 0, 1, 1, mk_e(8'hFE, 2, 1, 1));
    tbl[7] = mk(8'hAA, 8'h55, 1, 1, 1, mk_e(8'h00, 0, 1, 1));
    tbl[8] = mk(8'h12, 8'h34, 1, 1, 0, mk_e(8'h46, 0, 1, 0));

    #12;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_word",
        {ifc.out_sum, ifc.out_idx, ifc.out_last, ifc.out_cout}, 0);
    chk("rst_err_seq", err_seq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].l, tbl[i].c, tbl[i].e);
      chk("busy_after_word", busy, {31'd0, !tbl[i].l});
    end
    drain("drain_table");
    chk("err_after_table", err_seq, 0);

    ifc.out_ready = 1'b0;
    send(8'h10, 8'h20, 1, 0, 0, mk_e(8'h30, 0, 0, 0));
    ifc.in_a = 8'h05;
    ifc.in_b = 8'h06;
    ifc.in_first = 1'b0;
    ifc.in_last = 1'b1;
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", ifc.in_ready, 0);
      chk("bp_out_valid", ifc.out_valid, 1);
      chk("bp_hold", {ifc.out_sum, ifc.out_idx, ifc.out_last},
          {8'h30, 3'd0, 1'b0});
      step();
    end
    ifc.out_ready = 1'b1;
    send(8'h05, 8'h06, 0, 1, 0, mk_e(8'h0B, 1, 1, 0));
    drain("drain_bp");

    send(8'h01, 8'h02, 1, 0, 0, mk_e(8'h03, 0, 0, 0));
    chk("err_open_busy", busy, 1);
    chk("err_before", err_seq, 0);
    send(8'h05, 8'h06, 1, 0, 1, mk_e(8'h0C, 0, 0, 0));
    chk("err_first_in_busy", err_seq, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", err_seq, 0);
    send(8'h00, 8'h00, 0, 1, 0, mk_e(8'h00, 1, 1, 0));
    chk("err_close_busy", busy, 0);
    send(8'h03, 8'h04, 0, 1, 1, mk_e(8'h08, 0, 1, 0));
    chk("err_no_first_idle", err_seq, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr2", err_seq, 0);

    for (int k = 0; k < 9; k++) begin
      send(8'hFF, 8'h00, k == 0, k == 8, k == 0,
           mk_e(8'h00, k % 8, k == 8, k == 8));
      if (k == 6) chk("wrap_err_early", err_seq, 0);
      if (k == 7) chk("wrap_err", err_seq, 1);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drain("drain_wrap");

    send(8'hFF, 8'h01, 1, 0, 0, mk_e(8'h00, 0, 0, 0));
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    send(8'h01, 8'h01, 1, 1, 0, mk_e(8'h02, 0, 1, 0));
    drain("drain_rst");
    chk("end_err", err_seq, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
